// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer around a shared combinational FMA: acc = init + sum(a[i]*b[i]),
// one multiply-accumulate per accepted operand beat, result returned through a valid/ready port.
module fma_dot_sequencer #(
   parameter int E_MUL = 5,
   parameter int M_MUL = 10,
   parameter int E_ADD = 8,
   parameter int M_ADD = 23,
   parameter int LEN_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [LEN_W-1:0]       cfg_len,
   input  logic [E_ADD+M_ADD:0]   cfg_init,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [E_MUL+M_MUL:0]   op_a,
   input  logic [E_MUL+M_MUL:0]   op_b,
   input  logic                   abort,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [E_ADD+M_ADD:0]   res_data,
   output logic                   res_overflow,
   output logic                   busy,
   output logic [E_MUL+M_MUL:0]   fma_src0,
   output logic [E_MUL+M_MUL:0]   fma_src1,
   output logic [E_ADD+M_ADD:0]   fma_src2,
   input  logic [E_ADD+M_ADD:0]   fma_result,
   input  logic                   fma_overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [E_ADD+M_ADD:0]   acc_q, acc_d;
   logic [LEN_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;

   // State and datapath registers; reset discards any job in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state, register updates and handshake outputs.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      cfg_ready = 1'b0;
      op_ready  = 1'b0;
      res_valid = 1'b0;
      fma_src0  = '0;
      fma_src1  = '0;
      case (state_q)
         S_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               acc_d   = cfg_init;
               cnt_d   = cfg_len;
               ovf_d   = 1'b0;
               state_d = (cfg_len != {LEN_W{1'b0}}) ? S_RUN : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            fma_src0 = op_a;
            fma_src1 = op_b;
            // abort wins over a beat presented in the same cycle
            op_ready = ~abort;
            if (abort) begin
               state_d = S_IDLE;
            end else if (op_valid) begin
               acc_d = fma_result;
               ovf_d = ovf_q | fma_overflow;
               cnt_d = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
               if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fma_src2     = acc_q;
   assign res_data     = acc_q;
   assign res_overflow = ovf_q;
   assign busy         = (state_q != S_IDLE);

endmodule
